pkt_pad_ctrl: RTL and testbench
===============================

Name: pkt_pad_ctrl

Overview:
- Sequencer directly upstream of the 64-bit packet mux in the message-padding path.
- Accepts a stream of message words and forwards data words unchanged.
- Drives the mux selects pad_pkt, zero_pkt and mgln_pkt so the mux output forms complete BLK_WORDS-word blocks: data, then a pad word, then zero words, then the length word.
- Tracks the message bit length and the word index within the current block.

Parameters:
W, 64, data word width in bits; also the bit increment per accepted word.
BLK_WORDS, 16, words per block; must be a power of two and at least 4.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_data  input  W  message word.
in_valid  input  1  in_data is valid.
in_last  input  1  qualifies in_data as the final word of the message.
in_ready  output  1  this block accepts in_data this cycle.
pkt  output  W  in_data passed straight through to the mux pkt input.
msg_len  output  W  message bit length, to the mux msg_len input.
pad_pkt  output  1  mux select: pad word.
zero_pkt  output  1  mux select: zero word.
mgln_pkt  output  1  mux select: length word.
out_valid  output  1  mux output word is valid.
out_ready  input  1  downstream accepts the mux output word.
word_idx  output  log2(BLK_WORDS)  index of the current word within its block.
blk_last  output  1  current word is index BLK_WORDS-1.
msg_done  output  1  high during the length-word beat.

Behaviour:
- Reset (rst_n low, asynchronous): state=S_DATA, word_idx=0, msg_len=0.
  - All selects, out_valid, blk_last and msg_done are 0; in_ready=0 while rst_n is low.
  - Reset mid-message abandons it with no further output.
- Beat: a cycle with out_valid & out_ready. word_idx increments on each beat and wraps BLK_WORDS-1 -> 0. No state, counter or msg_len change occurs without a beat.
- Selects are one-hot or all zero, decoded combinationally from state. pkt = in_data at all times. Zero added latency: output is combinational from state and inputs.
- Each accepted data word adds W to msg_len, modulo 2^W (wraps silently).
- S_DATA:
  - out_valid = in_valid; in_ready = out_ready; selects all 0.
  - On a beat with in_last=1, go to S_PAD.
- S_PAD:
  - out_valid=1, pad_pkt=1, in_ready=0.
  - On a beat, go to S_ZERO. Exception: if word_idx==BLK_WORDS-2, go to S_ZERO and emit zero at BLK_WORDS-1, then continue in S_ZERO.
- S_ZERO:
  - out_valid=1, zero_pkt=1, in_ready=0.
  - Stays in S_ZERO through word index BLK_WORDS-2, which is the upper length word and is always zero.
  - On a beat at word_idx==BLK_WORDS-2, go to S_LEN.
  - Zero words at index BLK_WORDS-1 (spill case) do not trigger S_LEN; padding continues into the next block.
- S_LEN:
  - out_valid=1, mgln_pkt=1, msg_done=1; word_idx is always BLK_WORDS-1 here.
  - On a beat: msg_len clears to 0, word_idx wraps to 0, go to S_DATA.
- Spill boundaries:
  - Pad at index BLK_WORDS-2 or BLK_WORDS-1 forces one additional all-padding block.
  - Last data word at index BLK_WORDS-1 puts the pad word at index 0 of the next block.
- in_last is ignored unless in_valid=1. Every message carries at least one word.
- msg_len is stable from the pad beat through the length beat.

Test Plan:
- 1-word message, out_ready=1 -> 16 beats: data@0, pad@1 (0x8000000000000000 at mux output), zero@2..14, mgln@15 with msg_len=64; msg_done and blk_last high on beat 16.
- 14-word message -> data@0..13, pad@14, zero@15, then next block zero@0..14, mgln@15 with msg_len=896; 32 beats total.
- 15-word and 16-word messages -> 15 words: pad@15 of block 0, then len 960 at block 1 index 15. 16 words: pad@0 of block 1, len 1024 at block 1 index 15.
- Back-to-back messages, out_ready toggled 1,0,1,0 -> in_ready low whenever out_ready is low, and no state, word_idx or msg_len change on stalled cycles. Second message starts at word_idx=0 with msg_len restarting from 0.
- Reset asserted mid-S_ZERO, asynchronously between clock edges -> all outputs zero immediately. After release, a 2-word message produces len 128 at index 15.
- in_valid=0 gaps inside a 3-word message -> out_valid=0 during gaps, word_idx held; final length 192.

Source files
------------

// File: rtl/pkt_pad_ctrl.sv
// Padding sequencer ahead of the 64-bit packet mux: forwards message words, then
// steers the mux through pad, zero and length words to close out whole blocks.
module pkt_pad_ctrl #(
  parameter int W         = 64,
  parameter int BLK_WORDS = 16,
  localparam int IDX_W    = $clog2(BLK_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [W-1:0]     pkt,
  output logic [W-1:0]     msg_len,
  output logic             pad_pkt,
  output logic             zero_pkt,
  output logic             mgln_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] word_idx,
  output logic             blk_last,
  output logic             msg_done
);

  localparam logic [1:0] S_DATA = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;
  localparam logic [1:0] S_LEN  = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_PEN  = IDX_W'(BLK_WORDS - 2);
  localparam logic [W-1:0]     LEN_INC  = W'(W);

  if ((BLK_WORDS < 4) || ((BLK_WORDS & (BLK_WORDS - 1)) != 0)) begin : g_bad_blk_words
    $error("pkt_pad_ctrl: BLK_WORDS must be a power of two and at least 4");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [IDX_W-1:0] r_word_idx;
  logic [W-1:0]     r_msg_len;
  logic             w_beat;

  assign pkt      = in_data;
  assign msg_len  = r_msg_len;
  assign word_idx = r_word_idx;
  assign blk_last = (r_word_idx == IDX_LAST);
  assign w_beat   = out_valid & out_ready;

  // Handshake and selects; S_DATA gates on rst_n so nothing leaks out while reset is held.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    out_valid = 1'b0;
    in_ready  = 1'b0;
    pad_pkt   = 1'b0;
    zero_pkt  = 1'b0;
    mgln_pkt  = 1'b0;
    msg_done  = 1'b0;
    case (r_state)
      S_DATA: begin
        out_valid = in_valid & rst_n;
        in_ready  = out_ready & rst_n;
      end
      S_PAD: begin
        out_valid = 1'b1;
        pad_pkt   = 1'b1;
      end
      S_ZERO: begin
        out_valid = 1'b1;
        zero_pkt  = 1'b1;
      end
      default: begin
        out_valid = 1'b1;
        mgln_pkt  = 1'b1;
        msg_done  = 1'b1;
      end
    endcase
  end

  // A pad at the last two indices leaves no room for the length pair, so S_ZERO
  // only hands over to S_LEN from the penultimate index and otherwise spills on.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_DATA:  if (in_last) w_next_state = S_PAD;
      S_PAD:   w_next_state = S_ZERO;
      S_ZERO:  if (r_word_idx == IDX_PEN) w_next_state = S_LEN;
      default: w_next_state = S_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_DATA;
      r_word_idx <= '0;
      r_msg_len  <= '0;
    end else if (w_beat) begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      r_state    <= w_next_state;
      r_word_idx <= r_word_idx + IDX_W'(1);
      if (r_state == S_DATA) begin
        r_msg_len <= r_msg_len + LEN_INC;
      end else if (r_state == S_LEN) begin
        r_msg_len <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pkt_pad_ctrl.sv
// Scoreboard bench for pkt_pad_ctrl: expected mux words are queued per message from
// an independent block-layout model and compared on every output beat.
module tb_pkt_pad_ctrl;

  localparam int W   = 64;
  localparam int BLK = 16;
  localparam int IW  = 4;
  localparam logic [63:0] PAD_WORD = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [63:0] word;
    int          idx;
    bit          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [W-1:0]  pkt;
  logic [W-1:0]  msg_len;
  logic          pad_pkt;
  logic          zero_pkt;
  logic          mgln_pkt;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] word_idx;
  logic          blk_last;
  logic          msg_done;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   toggle_en = 1'b0;
  bit   gap_en    = 1'b0;

  logic [IW-1:0] prev_idx;
  logic [63:0]   prev_len;
  logic [2:0]    prev_sel;
  bit            prev_ok   = 1'b0;
  bit            prev_beat = 1'b0;
  bit            cur_beat;
  exp_t          cur_e;
  logic [63:0]   mux_word;

  pkt_pad_ctrl #(.W(W), .BLK_WORDS(BLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .pkt       (pkt),
    .msg_len   (msg_len),
    .pad_pkt   (pad_pkt),
    .zero_pkt  (zero_pkt),
    .mgln_pkt  (mgln_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_idx  (word_idx),
    .blk_last  (blk_last),
    .msg_done  (msg_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] data_word(input int id, input int i);
    return 64'hD000_0000_0000_0000 | (64'(id) << 16) | 64'(i);
  endfunction

  // Downstream ready: held high, or flipped every cycle during the stall test.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_en ? ~out_ready : 1'b1;
    end
  end

  // Monitor: beats popped against the scoreboard; idle cycles must not move anything.
  always @(negedge clk) begin
    cur_beat = out_valid & out_ready;
    if (rst_n) begin
      if (prev_ok && !prev_beat) begin
        check("hold_idx", 64'(word_idx), 64'(prev_idx));
        check("hold_len", msg_len, prev_len);
        check("hold_sel", 64'({pad_pkt, zero_pkt, mgln_pkt}), 64'(prev_sel));
      end
      check("sel_onehot", 64'($countones({pad_pkt, zero_pkt, mgln_pkt}) <= 1), 64'(1));
      if (!out_ready) check("stall_in_ready", 64'(in_ready), 64'(0));
      if (cur_beat) begin
        mux_word = pad_pkt ? PAD_WORD : zero_pkt ? 64'(0) : mgln_pkt ? msg_len : pkt;
        if (q.size() == 0) begin
          check("unexpected_beat", mux_word, 64'(0));
        end else begin
          cur_e = q.pop_front();
          check("mux_word", mux_word, cur_e.word);
          check("word_idx", 64'(word_idx), 64'(cur_e.idx));
          check("msg_done", 64'(msg_done), 64'(cur_e.done));
          check("blk_last", 64'(blk_last), 64'(cur_e.idx == BLK - 1));
        end
      end
    end
    prev_ok   = rst_n;
    prev_beat = cur_beat;
    prev_idx  = word_idx;
    prev_len  = msg_len;
    prev_sel  = {pad_pkt, zero_pkt, mgln_pkt};
  end

  // Layout model: data, pad, zeros, then the length word closing the first block
  // that can hold pad plus the two-word length field.
  task automatic push_msg(input int n, input int id);
    int total;
    exp_t e;
    total = ((n + 3 + BLK - 1) / BLK) * BLK;
    for (int b = 0; b < total; b++) begin
      e.idx  = b % BLK;
      e.done = (b == total - 1);
      if (b < n)               e.word = data_word(id, b);
      else if (b == n)         e.word = PAD_WORD;
      else if (b == total - 1) e.word = 64'(n * W);
      else                     e.word = 64'(0);
      q.push_back(e);
    end
  endtask

  task automatic drive_msg(input int n, input int id);
    bit acc;
    for (int i = 0; i < n; i++) begin
      if (gap_en) begin
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = 64'(32'($urandom));
        @(negedge clk);
        check("gap_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
      end
      in_data  = data_word(id, i);
      in_valid = 1'b1;
      in_last  = (i == n - 1);
      acc = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) check("accept_timeout", 64'(0), 64'(1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && q.size() > 0; c++) @(posedge clk);
    if (q.size() != 0) begin
      check("drain_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_in_ready"},  64'(in_ready),  64'(0));
    check({tag, "_sel"},       64'({pad_pkt, zero_pkt, mgln_pkt}), 64'(0));
    check({tag, "_done_last"}, 64'({msg_done, blk_last}), 64'(0));
    check({tag, "_word_idx"},  64'(word_idx), 64'(0));
    check({tag, "_msg_len"},   msg_len, 64'(0));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b1;
    in_last  = 1'b0;
    #1;
    check_reset_outputs("por");
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single messages across the no-spill and spill boundaries.
    push_msg(1, 1);  drive_msg(1, 1);  drain();
    push_msg(13, 2); drive_msg(13, 2); drain();
    push_msg(14, 3); drive_msg(14, 3); drain();
    push_msg(15, 4); drive_msg(15, 4); drain();
    push_msg(16, 5); drive_msg(16, 5); drain();

    // Back-to-back messages under a toggling downstream ready.
    toggle_en = 1'b1;
    push_msg(3, 6);
    push_msg(2, 7);
    drive_msg(3, 6);
    drive_msg(2, 7);
    drain();
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Idle gaps inside a message.
    gap_en = 1'b1;
    push_msg(3, 8); drive_msg(3, 8); drain();
    gap_en = 1'b0;

    // Asynchronous reset in the middle of the zero run abandons the message.
    push_msg(3, 9);
    drive_msg(3, 9);
    for (int c = 0; c < 50 && !zero_pkt; c++) @(negedge clk);
    check("reached_zero", 64'(zero_pkt), 64'(1));
    repeat (2) @(negedge clk);
    #2;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_msg(2, 10); drive_msg(2, 10); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
